// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scan-code sequencer. It pops bytes from the receiver FIFO, decodes the
// E0/F0 prefixes, filters typematic repeats and emits one clean event per make/break.
//
//   state     | meaning
//   S_IDLE    | no prefix pending
//   S_EXT     | E0 seen, waiting for code or F0
//   S_BRK     | F0 seen, next code is a break
//   S_EXT_BRK | E0 F0 seen, next code is an extended break
module ps2_scancode_ctrl #(
   parameter int PRESS_W       = 8,
   parameter bit REPEAT_FILTER = 1'b1,
   parameter int TIMEOUT_CYC   = 1000000
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               ready,
   input  logic [7:0]         rx_data,
   input  logic               overflow,
   output logic               rdn,
   input  logic               clr_ovf,
   output logic [7:0]         key_code,
   output logic               key_ext,
   output logic               key_down,
   output logic               evt_valid,
   output logic               evt_break,
   output logic [7:0]         evt_code,
   output logic [PRESS_W-1:0] press_cnt,
   output logic               ovf_sticky
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t             state_q;
   logic               pop_gap_q;
   logic               byte_vld_q;
   logic [7:0]         byte_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [7:0]         key_code_q;
   logic               key_ext_q;
   logic               key_down_q;
   logic               evt_valid_q;
   logic               evt_break_q;
   logic [7:0]         evt_code_q;
   logic [PRESS_W-1:0] press_cnt_q;
   logic               ovf_q;

   logic pop;
   logic ext_st;
   logic brk_st;
   logic held;
   logic tmo_fire;

   // Pop strobe is combinational so rdn can only be low while ready is high;
   // clrn gating keeps it inactive throughout reset.
   assign pop      = ready & ~pop_gap_q & clrn;
   assign rdn      = ~pop;

   assign ext_st   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
   assign brk_st   = (state_q == S_BRK) || (state_q == S_EXT_BRK);
   assign held     = key_down_q && (key_code_q == byte_q) && (key_ext_q == ext_st);
   assign tmo_fire = (state_q != S_IDLE) && (tmo_q == '0) && !byte_vld_q && !pop;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= S_IDLE;
         pop_gap_q   <= 1'b0;
         byte_vld_q  <= 1'b0;
         byte_q      <= 8'h00;
         tmo_q       <= '0;
         key_code_q  <= 8'h00;
         key_ext_q   <= 1'b0;
         key_down_q  <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_break_q <= 1'b0;
         evt_code_q  <= 8'h00;
         press_cnt_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         pop_gap_q   <= pop;
         byte_vld_q  <= pop;
         evt_valid_q <= 1'b0;
         if (pop) byte_q <= rx_data;

         if (overflow || tmo_fire) ovf_q <= 1'b1;
         else if (clr_ovf)         ovf_q <= 1'b0;

         if (pop || state_q == S_IDLE) tmo_q <= TMO_LAST;
         else if (tmo_q != '0)         tmo_q <= tmo_q - 1'b1;

         if (overflow) begin
            state_q <= S_IDLE;
         end else if (byte_vld_q) begin
            case (byte_q)
               8'hE0: state_q <= S_EXT;
               8'hF0: begin
                  if (state_q == S_IDLE)     state_q <= S_BRK;
                  else if (state_q == S_EXT) state_q <= S_EXT_BRK;
               end
               8'h00, 8'hFF: state_q <= S_IDLE;
               default: begin
                  state_q <= S_IDLE;
                  if (brk_st) begin
                     evt_valid_q <= 1'b1;
                     evt_break_q <= 1'b1;
                     evt_code_q  <= byte_q;
                     if (held) key_down_q <= 1'b0;
                  end else if (!(REPEAT_FILTER && held)) begin
                     evt_valid_q <= 1'b1;
                     evt_break_q <= 1'b0;
                     evt_code_q  <= byte_q;
                     key_code_q  <= byte_q;
                     key_ext_q   <= ext_st;
                     key_down_q  <= 1'b1;
                     press_cnt_q <= press_cnt_q + PRESS_W'(1);
                  end
               end
            endcase
         end else if (tmo_fire) begin
            state_q <= S_IDLE;
         end
      end
   end

   assign key_code   = key_code_q;
   assign key_ext    = key_ext_q;
   assign key_down   = key_down_q;
   assign evt_valid  = evt_valid_q;
   assign evt_break  = evt_break_q;
   assign evt_code   = evt_code_q;
   assign press_cnt  = press_cnt_q;
   assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Bench for ps2_scancode_ctrl: scan-code sequences in, expected events queued and
// compared as the DUT emits them. A second instance runs with the repeat filter off.
module tb_ps2_scancode_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic       ready;
   logic [7:0] rx_data;
   logic       overflow;
   logic       clr_ovf;

   logic       rdn, key_ext, key_down, evt_valid, evt_break, ovf_sticky;
   logic [7:0] key_code, evt_code, press_cnt;

   logic       nf_rdn, nf_key_ext, nf_key_down, nf_evt_valid, nf_evt_break, nf_ovf_sticky;
   logic [7:0] nf_key_code, nf_evt_code, nf_press_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_pop = -100;
   int rdn_lows = 0;
   int nf_makes = 0;

   typedef struct packed {
      logic       brk;
      logic [7:0] code;
      logic       kd;
      logic       ext;
      logic [7:0] kc;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [7:0] B2B [6] = '{8'h2B, 8'hF0, 8'h2B, 8'h3C, 8'hF0, 8'h3C};

   always #5 clk = ~clk;

   ps2_scancode_ctrl #(.PRESS_W(8), .REPEAT_FILTER(1'b1), .TIMEOUT_CYC(50)) dut (
      .clk(clk), .clrn(clrn), .ready(ready), .rx_data(rx_data), .overflow(overflow),
      .rdn(rdn), .clr_ovf(clr_ovf), .key_code(key_code), .key_ext(key_ext),
      .key_down(key_down), .evt_valid(evt_valid), .evt_break(evt_break),
      .evt_code(evt_code), .press_cnt(press_cnt), .ovf_sticky(ovf_sticky)
   );

   ps2_scancode_ctrl #(.PRESS_W(8), .REPEAT_FILTER(1'b0), .TIMEOUT_CYC(50)) dut_nf (
      .clk(clk), .clrn(clrn), .ready(ready), .rx_data(rx_data), .overflow(overflow),
      .rdn(nf_rdn), .clr_ovf(clr_ovf), .key_code(nf_key_code), .key_ext(nf_key_ext),
      .key_down(nf_key_down), .evt_valid(nf_evt_valid), .evt_break(nf_evt_break),
      .evt_code(nf_evt_code), .press_cnt(nf_press_cnt), .ovf_sticky(nf_ovf_sticky)
   );

   // Event scoreboard and pop-handshake monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      cyc++;
      if (evt_valid) begin
         checks++;
         got = '{evt_break, evt_code, key_down, key_ext, key_code};
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got brk=%b code=%h (none expected)", evt_break, evt_code);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL event got brk=%b code=%h kd=%b ext=%b kc=%h exp brk=%b code=%h kd=%b ext=%b kc=%h",
                        got.brk, got.code, got.kd, got.ext, got.kc, e.brk, e.code, e.kd, e.ext, e.kc);
            end
         end
         checks++;
         if (cyc - last_pop != 2) begin
            failures++;
            $display("FAIL event_latency got=%0d exp=2", cyc - last_pop);
         end
      end
      if (!rdn) begin
         checks++;
         if (ready !== 1'b1 || last_pop == cyc - 1) begin
            failures++;
            $display("FAIL rdn_strobe ready=%b gap=%0d exp ready=1 gap>=2", ready, cyc - last_pop);
         end
         last_pop = cyc;
         rdn_lows++;
      end
      if (nf_evt_valid && !nf_evt_break) nf_makes++;
   end

   task automatic push_evt(input logic brk, input logic [7:0] code, input logic kd,
                           input logic ext, input logic [7:0] kc);
      exp_t e;
      e = '{brk, code, kd, ext, kc};
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit seen;
      seen = 1'b0;
      @(posedge clk); #1;
      ready   = 1'b1;
      rx_data = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!rdn) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL pop_wait byte=%h got rdn=1 for 20 cycles exp rdn=0", b);
      end
      @(posedge clk); #1;
      ready = 1'b0;
   endtask

   task automatic drain;
      repeat (6) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_events got=%0d outstanding exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      clrn = 1'b0; ready = 1'b1; rx_data = 8'h15; overflow = 1'b0; clr_ovf = 1'b0;
      #12;
      checks++;
      if (rdn !== 1'b1) begin
         failures++;
         $display("FAIL reset_rdn got=%b exp=1", rdn);
      end
      checks++;
      if ({key_code, evt_code, press_cnt} !== 24'h0) begin
         failures++;
         $display("FAIL reset_bytes got=%h exp=000000", {key_code, evt_code, press_cnt});
      end
      checks++;
      if ({key_ext, key_down, evt_valid, evt_break, ovf_sticky} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000", {key_ext, key_down, evt_valid, evt_break, ovf_sticky});
      end
      ready = 1'b0;
      @(posedge clk); #2;
      clrn = 1'b1;
   endtask

   task automatic test_make_break;
      int lows0;
      lows0 = rdn_lows;
      push_evt(1'b0, 8'h15, 1'b1, 1'b0, 8'h15);
      send_byte(8'h15);
      repeat (3) @(negedge clk);
      checks++;
      if (key_down !== 1'b1 || press_cnt !== 8'd1) begin
         failures++;
         $display("FAIL make_state got kd=%b cnt=%0d exp kd=1 cnt=1", key_down, press_cnt);
      end
      send_byte(8'hF0);
      push_evt(1'b1, 8'h15, 1'b0, 1'b0, 8'h15);
      send_byte(8'h15);
      drain();
      checks++;
      if (key_down !== 1'b0 || press_cnt !== 8'd1) begin
         failures++;
         $display("FAIL break_state got kd=%b cnt=%0d exp kd=0 cnt=1", key_down, press_cnt);
      end
      checks++;
      if (rdn_lows - lows0 != 3) begin
         failures++;
         $display("FAIL rdn_count got=%0d exp=3", rdn_lows - lows0);
      end
   endtask

   task automatic test_repeat;
      logic [7:0] p0, np0;
      int m0;
      p0 = press_cnt; np0 = nf_press_cnt; m0 = nf_makes;
      push_evt(1'b0, 8'h1D, 1'b1, 1'b0, 8'h1D);
      send_byte(8'h1D);
      send_byte(8'h1D);
      send_byte(8'h1D);
      send_byte(8'hF0);
      push_evt(1'b1, 8'h1D, 1'b0, 1'b0, 8'h1D);
      send_byte(8'h1D);
      drain();
      checks++;
      if (press_cnt !== 8'(p0 + 1)) begin
         failures++;
         $display("FAIL repeat_filtered_cnt got=%0d exp=%0d", press_cnt, 8'(p0 + 1));
      end
      checks++;
      if (nf_press_cnt !== 8'(np0 + 3) || nf_makes - m0 != 3) begin
         failures++;
         $display("FAIL repeat_unfiltered got cnt=%0d makes=%0d exp cnt=%0d makes=3",
                  nf_press_cnt, nf_makes - m0, 8'(np0 + 3));
      end
   endtask

   task automatic test_extended;
      logic [7:0] p0;
      p0 = press_cnt;
      push_evt(1'b0, 8'h75, 1'b1, 1'b1, 8'h75);
      send_byte(8'hE0); send_byte(8'h75);
      push_evt(1'b1, 8'h75, 1'b0, 1'b1, 8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      push_evt(1'b0, 8'h75, 1'b1, 1'b1, 8'h75);
      send_byte(8'hE0); send_byte(8'h75);
      push_evt(1'b0, 8'h75, 1'b1, 1'b0, 8'h75);
      send_byte(8'h75);
      // extended break of a key not held (held one is plain 75): event, key stays down
      push_evt(1'b1, 8'h75, 1'b1, 1'b0, 8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      push_evt(1'b1, 8'h75, 1'b0, 1'b0, 8'h75);
      send_byte(8'hF0); send_byte(8'h75);
      push_evt(1'b0, 8'h74, 1'b1, 1'b1, 8'h74);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h74);
      push_evt(1'b1, 8'h74, 1'b0, 1'b1, 8'h74);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
      drain();
      checks++;
      if (press_cnt !== 8'(p0 + 4)) begin
         failures++;
         $display("FAIL ext_press_cnt got=%0d exp=%0d", press_cnt, 8'(p0 + 4));
      end
   endtask

   task automatic test_error_codes;
      push_evt(1'b0, 8'h33, 1'b1, 1'b0, 8'h33);
      send_byte(8'hF0); send_byte(8'hFF); send_byte(8'h33);
      send_byte(8'hE0); send_byte(8'h00); send_byte(8'h33);
      push_evt(1'b1, 8'h33, 1'b0, 1'b0, 8'h33);
      send_byte(8'hF0); send_byte(8'h33);
      drain();
   endtask

   task automatic test_timeout;
      logic [7:0] p0;
      p0 = press_cnt;
      send_byte(8'hF0);
      repeat (40) @(negedge clk);
      checks++;
      if (ovf_sticky !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early got=%b exp=0", ovf_sticky);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (ovf_sticky !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky got=%b exp=1", ovf_sticky);
      end
      push_evt(1'b0, 8'h15, 1'b1, 1'b0, 8'h15);
      send_byte(8'h15);
      drain();
      checks++;
      if (press_cnt !== 8'(p0 + 1)) begin
         failures++;
         $display("FAIL timeout_make_cnt got=%0d exp=%0d", press_cnt, 8'(p0 + 1));
      end
      @(posedge clk); #1 clr_ovf = 1'b1;
      @(posedge clk); #1 clr_ovf = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         failures++;
         $display("FAIL clr_ovf got=%b exp=0", ovf_sticky);
      end
      push_evt(1'b1, 8'h15, 1'b0, 1'b0, 8'h15);
      send_byte(8'hF0); send_byte(8'h15);
      drain();
   endtask

   task automatic test_overflow;
      logic [7:0] p0;
      p0 = press_cnt;
      send_byte(8'hF0);
      repeat (2) @(posedge clk);
      #1 overflow = 1'b1;
      @(posedge clk); #1 overflow = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b1) begin
         failures++;
         $display("FAIL overflow_sticky got=%b exp=1", ovf_sticky);
      end
      push_evt(1'b0, 8'h15, 1'b1, 1'b0, 8'h15);
      send_byte(8'h15);
      drain();
      checks++;
      if (press_cnt !== 8'(p0 + 1)) begin
         failures++;
         $display("FAIL overflow_make_cnt got=%0d exp=%0d", press_cnt, 8'(p0 + 1));
      end
      @(posedge clk); #1 begin overflow = 1'b1; clr_ovf = 1'b1; end
      @(posedge clk); #1 begin overflow = 1'b0; clr_ovf = 1'b0; end
      checks++;
      if (ovf_sticky !== 1'b1 || key_down !== 1'b1) begin
         failures++;
         $display("FAIL set_wins got ovf=%b kd=%b exp ovf=1 kd=1", ovf_sticky, key_down);
      end
      clr_ovf = 1'b1;
      @(posedge clk); #1 clr_ovf = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         failures++;
         $display("FAIL overflow_clear got=%b exp=0", ovf_sticky);
      end
      push_evt(1'b1, 8'h15, 1'b0, 1'b0, 8'h15);
      send_byte(8'hF0); send_byte(8'h15);
      drain();
   endtask

   task automatic test_back_to_back;
      logic [7:0] p0;
      int lows0;
      bit seen;
      p0 = press_cnt; lows0 = rdn_lows;
      push_evt(1'b0, 8'h2B, 1'b1, 1'b0, 8'h2B);
      push_evt(1'b1, 8'h2B, 1'b0, 1'b0, 8'h2B);
      push_evt(1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C);
      push_evt(1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C);
      @(posedge clk); #1 ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rx_data = B2B[i];
         seen = 1'b0;
         for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (!rdn) begin
               seen = 1'b1;
               break;
            end
         end
         checks++;
         if (!seen) begin
            failures++;
            $display("FAIL b2b_pop byte=%0d got rdn=1 exp rdn=0", i);
         end
         @(posedge clk); #1;
      end
      ready = 1'b0;
      drain();
      checks++;
      if (press_cnt !== 8'(p0 + 2) || rdn_lows - lows0 != 6) begin
         failures++;
         $display("FAIL b2b_counts got cnt=%0d pops=%0d exp cnt=%0d pops=6",
                  press_cnt, rdn_lows - lows0, 8'(p0 + 2));
      end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1 overflow = 1'b1;
      @(posedge clk); #1 overflow = 1'b0;
      push_evt(1'b0, 8'h1C, 1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);
      drain();
      send_byte(8'hF0);
      #2 clrn = 1'b0;
      #1;
      checks++;
      if ({key_code, evt_code, press_cnt, key_ext, key_down, evt_valid, evt_break, ovf_sticky, rdn} !== 30'h1) begin
         failures++;
         $display("FAIL async_reset got kc=%h ec=%h cnt=%h flags=%b rdn=%b exp all 0 rdn=1",
                  key_code, evt_code, press_cnt,
                  {key_ext, key_down, evt_valid, evt_break, ovf_sticky}, rdn);
      end
      @(posedge clk); #3 clrn = 1'b1;
      push_evt(1'b0, 8'h1C, 1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);
      drain();
      checks++;
      if (press_cnt !== 8'd1) begin
         failures++;
         $display("FAIL post_reset_cnt got=%0d exp=1", press_cnt);
      end
      push_evt(1'b1, 8'h1C, 1'b0, 1'b0, 8'h1C);
      send_byte(8'hF0); send_byte(8'h1C);
      drain();
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_repeat();
      test_extended();
      test_error_codes();
      test_timeout();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
